// File: rtl/dsp_psum_collect.sv
// Output stage of the DSP systolic array. It de-skews the bottom-row partial sums,
// accumulates groups of vectors and queues the finished sums for a valid/ready consumer.
module dsp_psum_collect #(
  parameter int COLS       = 4,
  parameter int DW         = 16,
  parameter int ACC_DW     = 32,
  parameter int LEN_W      = 16,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   clear,
  input  logic [LEN_W-1:0]       cfg_acc_len,
  input  logic                   in_valid,
  input  logic [COLS*DW-1:0]     psu_in,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [COLS*ACC_DW-1:0] out_data,
  output logic                   busy,
  output logic                   ovf_err
);

  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CNT_W = PTR_W + 1;

  logic [COLS*DW-1:0] aligned;
  logic               aligned_valid;
  logic               vsr_any;

  // Slot valid tracks column 0; it arrives COLS-1 cycles later with the aligned vector.
  generate
    if (COLS > 1) begin : g_vsr
      logic [COLS-2:0] vsr;
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          vsr <= '0;
        end else if (clear) begin
          vsr <= '0;
        end else begin
          vsr[0] <= in_valid;
          for (int k = 1; k < COLS - 1; k++) begin
            vsr[k] <= vsr[k-1];
          end
        end
      end
      assign aligned_valid = vsr[COLS-2];
      assign vsr_any       = |vsr;
    end else begin : g_novsr
      assign aligned_valid = in_valid;
      assign vsr_any       = 1'b0;
    end
  endgenerate

  // Lane c enters c cycles after its slot, so it needs COLS-1-c stages to line up.
  generate
    for (genvar c = 0; c < COLS; c++) begin : g_lane
      if (c == COLS - 1) begin : g_direct
        assign aligned[c*DW +: DW] = psu_in[c*DW +: DW];
      end else begin : g_pipe
        logic [DW-1:0] pipe [COLS-1-c];
        always_ff @(posedge clk or negedge rst_n) begin
          if (!rst_n) begin
            for (int k = 0; k < COLS - 1 - c; k++) begin
              pipe[k] <= '0;
            end
          end else begin
            pipe[0] <= psu_in[c*DW +: DW];
            for (int k = 1; k < COLS - 1 - c; k++) begin
              pipe[k] <= pipe[k-1];
            end
          end
        end
        assign aligned[c*DW +: DW] = pipe[COLS-2-c];
      end
    end
  endgenerate

  logic [LEN_W-1:0]       cnt;
  logic [LEN_W-1:0]       len_q;
  logic [LEN_W-1:0]       eff_len;
  logic                   last;
  logic [COLS*ACC_DW-1:0] acc;
  logic [COLS*ACC_DW-1:0] sum;

  // The group length is captured from cfg only when a group starts.
  always_comb begin
    eff_len = len_q;
    if (cnt == '0) begin
      eff_len = (cfg_acc_len == '0) ? LEN_W'(1) : cfg_acc_len;
    end
    last = ((LEN_W+1)'(cnt) + (LEN_W+1)'(1)) == (LEN_W+1)'(eff_len);
    sum  = '0;
    for (int c = 0; c < COLS; c++) begin
      sum[c*ACC_DW +: ACC_DW] = ((cnt == '0) ? '0 : acc[c*ACC_DW +: ACC_DW])
                              + ACC_DW'($signed(aligned[c*DW +: DW]));
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt   <= '0;
      len_q <= '0;
      acc   <= '0;
    end else if (clear) begin
      cnt   <= '0;
      len_q <= '0;
      acc   <= '0;
    end else if (aligned_valid) begin
      if (cnt == '0) begin
        len_q <= eff_len;
      end
      if (last) begin
        cnt <= '0;
      end else begin
        cnt <= cnt + LEN_W'(1);
        acc <= sum;
      end
    end
  end

  // Handshake: the head transfers on a cycle where out_valid && out_ready are both high;
  // while out_valid is high and out_ready low, out_data holds its value.
  logic [COLS*ACC_DW-1:0] mem [FIFO_DEPTH];
  logic [PTR_W-1:0]       wr_ptr;
  logic [PTR_W-1:0]       rd_ptr;
  logic [CNT_W-1:0]       count;
  logic                   push_req;
  logic                   push;
  logic                   pop;
  logic                   full;
  logic                   drop;

  assign full     = (count == CNT_W'(FIFO_DEPTH));
  assign pop      = out_valid && out_ready;
  assign push_req = aligned_valid && last;
  assign push     = push_req && (!full || pop);
  assign drop     = push_req && full && !pop;

  always_ff @(posedge clk) begin
    if (push && !clear) begin
      mem[wr_ptr] <= sum;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count   <= '0;
      ovf_err <= 1'b0;
    end else if (clear) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count   <= '0;
      ovf_err <= 1'b0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      if (push && !pop) begin
        count <= count + CNT_W'(1);
      end else if (pop && !push) begin
        count <= count - CNT_W'(1);
      end
      if (drop) begin
        ovf_err <= 1'b1;
      end
    end
  end

  assign out_valid = (count != '0);
  assign out_data  = out_valid ? mem[rd_ptr] : '0;
  assign busy      = vsr_any || (cnt != '0);

endmodule

// File: tb/tb_dsp_psum_collect.sv
// Directed bench for dsp_psum_collect with COLS=4, DW=16, ACC_DW=32, FIFO_DEPTH=4.
module tb_dsp_psum_collect;

  logic         clk;
  logic         rst_n;
  logic         clear;
  logic [15:0]  cfg_acc_len;
  logic         in_valid;
  logic [63:0]  psu_in;
  logic         out_valid;
  logic         out_ready;
  logic [127:0] out_data;
  logic         busy;
  logic         ovf_err;

  int n_checks = 0;
  int n_fail   = 0;

  logic [15:0] slot_val [8][4];
  logic [15:0] ov_hist;

  dsp_psum_collect #(
    .COLS(4), .DW(16), .ACC_DW(32), .LEN_W(16), .FIFO_DEPTH(4)
  ) dut (
    .clk(clk), .rst_n(rst_n), .clear(clear), .cfg_acc_len(cfg_acc_len),
    .in_valid(in_valid), .psu_in(psu_in), .out_valid(out_valid),
    .out_ready(out_ready), .out_data(out_data), .busy(busy), .ovf_err(ovf_err)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  // driver tasks: every task starts and ends just after a falling edge
  task automatic set_slot(input int s, input logic [15:0] a, input logic [15:0] b,
                          input logic [15:0] c, input logic [15:0] d);
    slot_val[s][0] = a;
    slot_val[s][1] = b;
    slot_val[s][2] = c;
    slot_val[s][3] = d;
  endtask

  // Sends n slots on consecutive cycles with lane c skewed by c cycles.
  // out_ready is high only on relative cycle ready_k; returns at cycle t+n+3.
  task automatic send_slots(input int n, input int ready_k);
    ov_hist = '0;
    for (int k = 0; k < n + 3; k++) begin
      ov_hist[k] = out_valid;
      in_valid   = (k < n);
      out_ready  = (k == ready_k);
      for (int c = 0; c < 4; c++) begin
        int s;
        s = k - c;
        if (s >= 0 && s < n) psu_in[c*16 +: 16] = slot_val[s][c];
        else psu_in[c*16 +: 16] = 16'hBEEF;
      end
      @(negedge clk);
    end
    in_valid  = 1'b0;
    out_ready = 1'b0;
    psu_in    = '0;
  endtask

  task automatic pop(output logic [127:0] d, output logic ok);
    int w;
    w = 0;
    while (out_valid !== 1'b1 && w < 20) begin
      @(negedge clk);
      w++;
    end
    ok = out_valid;
    d  = out_data;
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
  endtask

  task automatic pulse_clear();
    clear = 1'b1;
    @(negedge clk);
    clear = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    clear = 1'b0; cfg_acc_len = 16'd1; in_valid = 1'b0; psu_in = '0; out_ready = 1'b0;
    repeat (3) @(negedge clk);
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid: got %b expected 0", out_valid); end
    n_checks++; if (out_data !== 128'h0) begin n_fail++; $display("FAIL reset_out_data: got %h expected 0", out_data); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b expected 0", busy); end
    n_checks++; if (ovf_err !== 1'b0) begin n_fail++; $display("FAIL reset_ovf_err: got %b expected 0", ovf_err); end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_len1();
    logic [127:0] d;
    logic ok;
    cfg_acc_len = 16'd1;
    set_slot(0, 16'd10, 16'd20, 16'd30, 16'd40);
    send_slots(1, -1);
    n_checks++; if (ov_hist[3:0] !== 4'b0000) begin n_fail++; $display("FAIL len1_early_valid: got %b expected 0000", ov_hist[3:0]); end
    n_checks++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL len1_latency: out_valid got %b expected 1 at t+4", out_valid); end
    n_checks++; if (out_data !== 128'h00000028_0000001E_00000014_0000000A) begin n_fail++; $display("FAIL len1_data: got %h expected 00000028_0000001e_00000014_0000000a", out_data); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL len1_busy: got %b expected 0", busy); end
    pop(d, ok);
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL len1_after_pop: out_valid got %b expected 0", out_valid); end
  endtask

  task automatic test_len3_sign();
    logic [127:0] d;
    logic ok;
    cfg_acc_len = 16'd3;
    set_slot(0, 16'd1, 16'd1, 16'd1, 16'd1);
    set_slot(1, 16'd2, 16'd2, 16'd2, 16'd2);
    set_slot(2, 16'd3, 16'd3, 16'd3, 16'd3);
    send_slots(3, -1);
    n_checks++; if (ov_hist[5:0] !== 6'b0) begin n_fail++; $display("FAIL len3_early_valid: got %b expected 000000", ov_hist[5:0]); end
    pop(d, ok);
    n_checks++; if (ok !== 1'b1) begin n_fail++; $display("FAIL len3_valid: got %b expected 1", ok); end
    n_checks++; if (d !== 128'h00000006_00000006_00000006_00000006) begin n_fail++; $display("FAIL len3_data: got %h expected 6 in every lane", d); end
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL len3_single_output: out_valid got %b expected 0", out_valid); end
    cfg_acc_len = 16'd1;
    set_slot(0, 16'hFFFB, 16'h0007, 16'h8000, 16'h7FFF);
    send_slots(1, -1);
    pop(d, ok);
    n_checks++; if (d !== 128'h00007FFF_FFFF8000_00000007_FFFFFFFB) begin n_fail++; $display("FAIL sign_ext_data: got %h expected 00007fff_ffff8000_00000007_fffffffb", d); end
  endtask

  task automatic test_backpressure();
    logic [127:0] d;
    logic ok;
    logic [127:0] exp_v [4];
    exp_v[0] = 128'h00000004_00000003_00000002_00000001;
    exp_v[1] = 128'h00000014_00000013_00000012_00000011;
    exp_v[2] = 128'h00000024_00000023_00000022_00000021;
    exp_v[3] = 128'h00000034_00000033_00000032_00000031;
    cfg_acc_len = 16'd1;
    for (int s = 0; s < 4; s++) begin
      set_slot(s, 16'(s*16+1), 16'(s*16+2), 16'(s*16+3), 16'(s*16+4));
    end
    send_slots(4, -1);
    n_checks++; if (ovf_err !== 1'b0) begin n_fail++; $display("FAIL bp_full_no_err: ovf_err got %b expected 0", ovf_err); end
    set_slot(0, 16'h41, 16'h42, 16'h43, 16'h44);
    send_slots(1, -1);
    n_checks++; if (ovf_err !== 1'b1) begin n_fail++; $display("FAIL bp_overflow: ovf_err got %b expected 1", ovf_err); end
    for (int i = 0; i < 4; i++) begin
      pop(d, ok);
      n_checks++; if (ok !== 1'b1 || d !== exp_v[i]) begin n_fail++; $display("FAIL bp_drain_%0d: valid %b data %h expected valid 1 data %h", i, ok, d, exp_v[i]); end
    end
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL bp_drained_empty: out_valid got %b expected 0", out_valid); end
    n_checks++; if (ovf_err !== 1'b1) begin n_fail++; $display("FAIL bp_sticky: ovf_err got %b expected 1", ovf_err); end
  endtask

  task automatic test_push_pop_full();
    logic [127:0] d;
    logic ok;
    logic [127:0] exp_v [4];
    exp_v[0] = 128'h00000064_00000063_00000062_00000061;
    exp_v[1] = 128'h00000074_00000073_00000072_00000071;
    exp_v[2] = 128'h00000084_00000083_00000082_00000081;
    exp_v[3] = 128'h00000094_00000093_00000092_00000091;
    pulse_clear();
    n_checks++; if (ovf_err !== 1'b0) begin n_fail++; $display("FAIL clear_ovf: ovf_err got %b expected 0", ovf_err); end
    cfg_acc_len = 16'd1;
    for (int s = 0; s < 4; s++) begin
      set_slot(s, 16'(s*16+16'h51), 16'(s*16+16'h52), 16'(s*16+16'h53), 16'(s*16+16'h54));
    end
    send_slots(4, -1);
    set_slot(0, 16'h91, 16'h92, 16'h93, 16'h94);
    send_slots(1, 3);
    n_checks++; if (ovf_err !== 1'b0) begin n_fail++; $display("FAIL pp_full_no_err: ovf_err got %b expected 0", ovf_err); end
    for (int i = 0; i < 4; i++) begin
      pop(d, ok);
      n_checks++; if (ok !== 1'b1 || d !== exp_v[i]) begin n_fail++; $display("FAIL pp_drain_%0d: valid %b data %h expected valid 1 data %h", i, ok, d, exp_v[i]); end
    end
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL pp_count4: out_valid got %b expected 0 after 4 pops", out_valid); end
  endtask

  task automatic test_len0_and_change();
    logic [127:0] d;
    logic ok;
    cfg_acc_len = 16'd0;
    set_slot(0, 16'd9, 16'd8, 16'd7, 16'd6);
    send_slots(1, -1);
    n_checks++; if (out_valid !== 1'b1 || out_data !== 128'h00000006_00000007_00000008_00000009) begin n_fail++; $display("FAIL len0_as_1: valid %b data %h expected valid 1 data 00000006_00000007_00000008_00000009", out_valid, out_data); end
    pop(d, ok);
    cfg_acc_len = 16'd2;
    set_slot(0, 16'd5, 16'd5, 16'd5, 16'd5);
    send_slots(1, -1);
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL len2_mid_group: out_valid got %b expected 0", out_valid); end
    cfg_acc_len = 16'd1;
    set_slot(0, 16'd7, 16'd7, 16'd7, 16'd7);
    send_slots(1, -1);
    set_slot(0, 16'd9, 16'd9, 16'd9, 16'd9);
    send_slots(1, -1);
    pop(d, ok);
    n_checks++; if (ok !== 1'b1 || d !== 128'h0000000C_0000000C_0000000C_0000000C) begin n_fail++; $display("FAIL len_change_old_group: valid %b data %h expected 12 in every lane", ok, d); end
    pop(d, ok);
    n_checks++; if (ok !== 1'b1 || d !== 128'h00000009_00000009_00000009_00000009) begin n_fail++; $display("FAIL len_change_new_group: valid %b data %h expected 9 in every lane", ok, d); end
  endtask

  task automatic test_abort(input logic use_reset);
    logic [127:0] d;
    logic ok;
    cfg_acc_len = 16'd3;
    set_slot(0, 16'd100, 16'd100, 16'd100, 16'd100);
    send_slots(1, -1);
    n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL abort%0d_busy_mid: got %b expected 1", use_reset, busy); end
    if (use_reset) begin
      rst_n = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
    end else begin
      pulse_clear();
    end
    n_checks++; if (busy !== 1'b0 || out_valid !== 1'b0) begin n_fail++; $display("FAIL abort%0d_flushed: busy %b out_valid %b expected 0 0", use_reset, busy, out_valid); end
    set_slot(0, 16'd1, 16'd1, 16'd1, 16'd1);
    set_slot(1, 16'd2, 16'd2, 16'd2, 16'd2);
    set_slot(2, 16'd3, 16'd3, 16'd3, 16'd3);
    send_slots(2, -1);
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL abort%0d_no_output: out_valid got %b expected 0", use_reset, out_valid); end
    set_slot(0, 16'd3, 16'd3, 16'd3, 16'd3);
    send_slots(1, -1);
    pop(d, ok);
    n_checks++; if (ok !== 1'b1 || d !== 128'h00000006_00000006_00000006_00000006) begin n_fail++; $display("FAIL abort%0d_post_data: valid %b data %h expected 6 in every lane", use_reset, ok, d); end
  endtask

  // scenario sequence and final report
  initial begin
    test_reset();
    test_len1();
    test_len3_sign();
    test_backpressure();
    test_push_pop_full();
    test_len0_and_change();
    test_abort(1'b0);
    test_abort(1'b1);
    repeat (2) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
